// File: rtl/hazard_pipe_tracker.sv
// Tracks rd/regwrite/memread through ID/EX, EX/MEM and MEM/WB, detects load-use
// hazards and sequences stall, bubble, freeze and deferred-flush behaviour.
module hazard_pipe_tracker (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rd,
    input  logic        dec_regwrite,
    input  logic        dec_memread,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        flush,
    input  logic        mem_busy,
    output logic [4:0]  idex_rd,
    output logic        idex_regwrite,
    output logic        idex_memread,
    output logic [4:0]  RD_ex_mem,
    output logic        EX_MEM_RegWrite,
    output logic [4:0]  RD_mem_wb,
    output logic        MEM_WB_RegWrite,
    output logic        stall,
    output logic        freeze,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_BUBBLE = 2'b01;
    localparam logic [1:0] ST_FREEZE = 2'b10;

    logic [1:0]  state_q, state_d;
    logic        pending_flush_q, pending_flush_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [4:0]  idex_rd_q, idex_rd_d;
    logic        idex_regwrite_q, idex_regwrite_d;
    logic        idex_memread_q, idex_memread_d;
    logic [4:0]  exmem_rd_q;
    logic        exmem_regwrite_q;
    logic        exmem_memread_q;
    logic [4:0]  memwb_rd_q;
    logic        memwb_regwrite_q;

    logic        load_use;
    logic        eff_flush;
    logic        insert_bubble;
    logic [1:0]  src_use;
    logic [4:0]  src_reg [2];
    logic [1:0]  src_hit;

    assign src_use    = {id_uses_rs2, id_uses_rs1};
    assign src_reg[0] = id_rs1;
    assign src_reg[1] = id_rs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] && (idex_rd_q == src_reg[gi]);
        end
    endgenerate

    // x0 never produces a hazard, so a load targeting x0 is not waited on.
    assign load_use      = dec_valid && idex_memread_q && (idex_rd_q != 5'd0) && (|src_hit);
    assign eff_flush     = flush || pending_flush_q;
    assign insert_bubble = eff_flush || load_use || !dec_valid;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = ST_RUN;
        if (mem_busy) begin
            state_d = ST_FREEZE;
        end else begin
            case (state_q)
                ST_RUN:    state_d = (load_use && !eff_flush) ? ST_BUBBLE : ST_RUN;
                ST_BUBBLE: state_d = ST_RUN;
                ST_FREEZE: state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        freeze = mem_busy;
        stall  = mem_busy || (load_use && !eff_flush);
    end

    // A flush seen while frozen is remembered and applied on the first free edge.
    always_comb begin
        pending_flush_d = pending_flush_q;
        if (mem_busy) begin
            if (flush) begin
                pending_flush_d = 1'b1;
            end
        end else begin
            pending_flush_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_flush_q <= 1'b0;
        end else begin
            pending_flush_q <= pending_flush_d;
        end
    end

    always_comb begin
        idex_rd_d       = dec_rd;
        idex_regwrite_d = dec_regwrite;
        idex_memread_d  = dec_memread;
        if (insert_bubble) begin
            idex_rd_d       = 5'd0;
            idex_regwrite_d = 1'b0;
            idex_memread_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_rd_q        <= 5'd0;
            idex_regwrite_q  <= 1'b0;
            idex_memread_q   <= 1'b0;
            exmem_rd_q       <= 5'd0;
            exmem_regwrite_q <= 1'b0;
            exmem_memread_q  <= 1'b0;
            memwb_rd_q       <= 5'd0;
            memwb_regwrite_q <= 1'b0;
        end else if (!mem_busy) begin
            memwb_rd_q       <= exmem_rd_q;
            memwb_regwrite_q <= exmem_regwrite_q;
            exmem_rd_q       <= idex_rd_q;
            exmem_regwrite_q <= idex_regwrite_q;
            exmem_memread_q  <= idex_memread_q;
            idex_rd_q        <= idex_rd_d;
            idex_regwrite_q  <= idex_regwrite_d;
            idex_memread_q   <= idex_memread_d;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // EX/MEM memread is tracked for completeness but nothing downstream reads it.
    logic unused_exmem_memread;
    assign unused_exmem_memread = exmem_memread_q;

    assign idex_rd         = idex_rd_q;
    assign idex_regwrite   = idex_regwrite_q;
    assign idex_memread    = idex_memread_q;
    assign RD_ex_mem       = exmem_rd_q;
    assign EX_MEM_RegWrite = exmem_regwrite_q;
    assign RD_mem_wb       = memwb_rd_q;
    assign MEM_WB_RegWrite = memwb_regwrite_q;
    assign state           = state_q;
    assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Bench for hazard_pipe_tracker: directed vector table, async-reset sequences,
// randomized run against a queue-based reference model, and counter saturation.
module tb_hazard_pipe_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dec_valid = 1'b0;
    logic [4:0]  dec_rd = '0;
    logic        dec_regwrite = 1'b0;
    logic        dec_memread = 1'b0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic        id_uses_rs1 = 1'b0;
    logic        id_uses_rs2 = 1'b0;
    logic        flush = 1'b0;
    logic        mem_busy = 1'b0;
    logic [4:0]  idex_rd;
    logic        idex_regwrite;
    logic        idex_memread;
    logic [4:0]  RD_ex_mem;
    logic        EX_MEM_RegWrite;
    logic [4:0]  RD_mem_wb;
    logic        MEM_WB_RegWrite;
    logic        stall;
    logic        freeze;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    hazard_pipe_tracker dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rd(dec_rd), .dec_regwrite(dec_regwrite), .dec_memread(dec_memread),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .flush(flush), .mem_busy(mem_busy),
        .idex_rd(idex_rd), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
        .RD_ex_mem(RD_ex_mem), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .RD_mem_wb(RD_mem_wb), .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .stall(stall), .freeze(freeze), .state(state), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       dv;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       fl;
        logic       busy;
        logic       e_stall;
        logic [1:0] e_state;
        logic [4:0] e_idex_rd;
        logic       e_idex_mr;
        logic [4:0] e_em_rd;
        logic [4:0] e_mw_rd;
        int         e_cnt;
    } vec_t;

    function automatic vec_t mkv(input logic dv, input int rd, input logic rw, input logic mr,
                                 input int rs1, input int rs2, input logic u1, input logic u2,
                                 input logic fl, input logic busy,
                                 input logic e_stall, input int e_state, input int e_idex_rd,
                                 input logic e_idex_mr, input int e_em_rd, input int e_mw_rd,
                                 input int e_cnt);
        vec_t v;
        v.dv = dv; v.rd = 5'(rd); v.rw = rw; v.mr = mr;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2; v.fl = fl; v.busy = busy;
        v.e_stall = e_stall; v.e_state = 2'(e_state); v.e_idex_rd = 5'(e_idex_rd);
        v.e_idex_mr = e_idex_mr; v.e_em_rd = 5'(e_em_rd); v.e_mw_rd = 5'(e_mw_rd); v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic drive(input logic dv, input logic [4:0] rd, input logic rw, input logic mr,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic fl, input logic busy);
        dec_valid = dv; dec_rd = rd; dec_regwrite = rw; dec_memread = mr;
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        flush = fl; mem_busy = busy;
    endtask

    // Reference model: pipeline as a queue of slots, index 0 = ID/EX.
    typedef struct packed {
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } slot_t;
    localparam slot_t BUB = 7'd0;

    slot_t m_pipe[$];
    int    m_state;
    bit    m_pend;
    int    m_cnt;

    function automatic void model_reset();
        m_pipe  = '{BUB, BUB, BUB};
        m_state = 0;
        m_pend  = 1'b0;
        m_cnt   = 0;
    endfunction

    task automatic model_check_and_step(input int cyc);
        bit    lu, eff, e_stall;
        slot_t nxt;
        lu = dec_valid && m_pipe[0].mr && (m_pipe[0].rd != 0) &&
             ((id_uses_rs1 && id_rs1 == m_pipe[0].rd) || (id_uses_rs2 && id_rs2 == m_pipe[0].rd));
        eff     = flush || m_pend;
        e_stall = mem_busy || (lu && !eff);
        chk($sformatf("rnd%0d idex_rd", cyc), 32'(idex_rd), 32'(m_pipe[0].rd));
        chk($sformatf("rnd%0d idex_rw", cyc), 32'(idex_regwrite), 32'(m_pipe[0].rw));
        chk($sformatf("rnd%0d idex_mr", cyc), 32'(idex_memread), 32'(m_pipe[0].mr));
        chk($sformatf("rnd%0d exmem_rd", cyc), 32'(RD_ex_mem), 32'(m_pipe[1].rd));
        chk($sformatf("rnd%0d exmem_rw", cyc), 32'(EX_MEM_RegWrite), 32'(m_pipe[1].rw));
        chk($sformatf("rnd%0d memwb_rd", cyc), 32'(RD_mem_wb), 32'(m_pipe[2].rd));
        chk($sformatf("rnd%0d memwb_rw", cyc), 32'(MEM_WB_RegWrite), 32'(m_pipe[2].rw));
        chk($sformatf("rnd%0d stall", cyc), 32'(stall), 32'(e_stall));
        chk($sformatf("rnd%0d freeze", cyc), 32'(freeze), 32'(mem_busy));
        chk($sformatf("rnd%0d state", cyc), 32'(state), 32'(m_state));
        chk($sformatf("rnd%0d stall_cnt", cyc), 32'(stall_cnt), 32'(m_cnt));
        if (mem_busy) begin
            m_state = 2;
            if (flush) m_pend = 1'b1;
        end else begin
            nxt = (eff || lu || !dec_valid) ? BUB : slot_t'({dec_rd, dec_regwrite, dec_memread});
            m_pipe.push_front(nxt);
            void'(m_pipe.pop_back());
            m_state = (m_state == 0 && lu && !eff) ? 1 : 0;
            m_pend  = 1'b0;
        end
        if (e_stall && m_cnt < 65535) m_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = mkv(1, 7, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mkv(1, 5, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 7, 0, 0, 0, 0);
        vecs[2]  = mkv(1, 9, 1, 0, 5, 0, 1, 0, 0, 0,   1, 0, 5, 1, 7, 0, 0);
        vecs[3]  = mkv(1, 9, 1, 0, 5, 0, 1, 0, 0, 0,   0, 1, 0, 0, 5, 7, 1);
        vecs[4]  = mkv(1, 3, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 9, 0, 0, 5, 1);
        vecs[5]  = mkv(1, 4, 1, 0, 0, 3, 0, 1, 1, 0,   0, 0, 3, 1, 9, 0, 1);
        vecs[6]  = mkv(1, 8, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 9, 1);
        vecs[7]  = mkv(1, 6, 1, 0, 0, 0, 0, 0, 0, 1,   1, 0, 8, 0, 0, 3, 1);
        vecs[8]  = mkv(1, 6, 1, 0, 0, 0, 0, 0, 1, 1,   1, 2, 8, 0, 0, 3, 2);
        vecs[9]  = mkv(1, 6, 1, 0, 0, 0, 0, 0, 0, 1,   1, 2, 8, 0, 0, 3, 3);
        vecs[10] = mkv(1, 6, 1, 0, 0, 0, 0, 0, 0, 0,   0, 2, 8, 0, 0, 3, 4);
        vecs[11] = mkv(1, 6, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 8, 0, 4);
        vecs[12] = mkv(1, 0, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 6, 0, 0, 8, 4);
        vecs[13] = mkv(1, 2, 1, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 6, 0, 4);

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset idex_rd", 32'(idex_rd), 0);
        chk("reset idex_mr", 32'(idex_memread), 0);
        chk("reset exmem_rd", 32'(RD_ex_mem), 0);
        chk("reset memwb_rd", 32'(RD_mem_wb), 0);
        chk("reset state", 32'(state), 0);
        chk("reset stall_cnt", 32'(stall_cnt), 0);
        chk("reset stall", 32'(stall), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].dv, vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].u1, vecs[i].u2, vecs[i].fl, vecs[i].busy);
            @(negedge clk);
            chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d freeze", i), 32'(freeze), 32'(vecs[i].busy));
            chk($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].e_state));
            chk($sformatf("v%0d idex_rd", i), 32'(idex_rd), 32'(vecs[i].e_idex_rd));
            chk($sformatf("v%0d idex_mr", i), 32'(idex_memread), 32'(vecs[i].e_idex_mr));
            chk($sformatf("v%0d exmem_rd", i), 32'(RD_ex_mem), 32'(vecs[i].e_em_rd));
            chk($sformatf("v%0d memwb_rd", i), 32'(RD_mem_wb), 32'(vecs[i].e_mw_rd));
            chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_cnt));
            $display("vec %0d: stall=%0b state=%0d idex=%0d exmem=%0d memwb=%0d cnt=%0d",
                     i, stall, state, idex_rd, RD_ex_mem, RD_mem_wb, stall_cnt);
            @(posedge clk); #1;
        end

        // Async reset while in BUBBLE
        drive(1, 5, 1, 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, 9, 1, 0, 5, 0, 1, 0, 0, 0);
        @(posedge clk); #1;
        chk("bubble entered", 32'(state), 1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("async rst bubble state", 32'(state), 0);
        chk("async rst bubble exmem_rd", 32'(RD_ex_mem), 0);
        chk("async rst bubble stall_cnt", 32'(stall_cnt), 0);
        $display("async reset from BUBBLE: state=%0d exmem=%0d cnt=%0d", state, RD_ex_mem, stall_cnt);
        @(posedge clk); #1;
        rst = 1'b0;

        // Async reset while frozen with a pending flush; the flush must be forgotten
        drive(1, 12, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, 13, 1, 0, 0, 0, 0, 0, 1, 1);
        @(posedge clk); #1;
        chk("freeze entered", 32'(state), 2);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("async rst freeze state", 32'(state), 0);
        chk("async rst freeze idex_rd", 32'(idex_rd), 0);
        chk("async rst freeze stall", 32'(stall), 0);
        chk("async rst freeze stall_cnt", 32'(stall_cnt), 0);
        @(negedge clk); #1;
        rst = 1'b0;
        drive(1, 11, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("post rst pending discarded", 32'(idex_rd), 11);
        chk("post rst state", 32'(state), 0);
        $display("after reset release: idex=%0d state=%0d", idex_rd, state);

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 1'($urandom),
                  1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0);
            @(negedge clk);
            model_check_and_step(c);
            @(posedge clk); #1;
        end
        $display("random phase: %0d cycles, model stall_cnt=%0d", 3000, m_cnt);

        // Counter saturation under a long freeze
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("sat cnt 65534", 32'(stall_cnt), 32'hFFFE);
        @(posedge clk);
        @(negedge clk);
        chk("sat cnt 65535", 32'(stall_cnt), 32'hFFFF);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sat cnt held", 32'(stall_cnt), 32'hFFFF);
        chk("sat state", 32'(state), 2);
        chk("sat freeze", 32'(freeze), 1);
        $display("saturation: stall_cnt=%0h state=%0d", stall_cnt, state);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_pipe_tracker.md
HAZARD_PIPE_TRACKER -- requirements
Module: hazard_pipe_tracker

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have inputs dec_valid (1), dec_rd (5), dec_regwrite (1) and dec_memread (1): the instruction currently in decode and its destination, write-enable and load flag.
REQ-004 SHALL have inputs id_rs1 (5), id_rs2 (5), id_uses_rs1 (1) and id_uses_rs2 (1): the decode-stage source registers and whether each is read.
REQ-005 SHALL have input flush (1): taken branch or jump resolved in EX; kills the decode-stage instruction.
REQ-006 SHALL have input mem_busy (1): data memory not ready; freezes the whole tracked pipeline.
REQ-007 SHALL have outputs idex_rd (5), idex_regwrite (1) and idex_memread (1): the ID/EX slot contents.
REQ-008 SHALL have outputs RD_ex_mem (5), EX_MEM_RegWrite (1), RD_mem_wb (5) and MEM_WB_RegWrite (1): the EX/MEM and MEM/WB slot contents, driven directly to forwarding logic.
REQ-009 SHALL have outputs stall (1) to hold PC and IF/ID, freeze (1) to hold all pipeline registers, and state (2).
REQ-010 SHALL have output stall_cnt (16): saturating count of stalled cycles.

Function
REQ-011 Three slots SHALL exist: ID/EX {rd, regwrite, memread}, EX/MEM {rd, regwrite, memread}, MEM/WB {rd, regwrite}.
REQ-012 A bubble SHALL be rd=0, regwrite=0, memread=0.
REQ-013 load_use (combinational) SHALL be: dec_valid && idex_memread && idex_rd!=0 && ((id_uses_rs1 && idex_rd==id_rs1) || (id_uses_rs2 && idex_rd==id_rs2)).
REQ-014 The FSM states SHALL be RUN=2'b00, BUBBLE=2'b01 and FREEZE=2'b10.
REQ-015 Transitions SHALL be: any state -> FREEZE when mem_busy=1.
REQ-016 Transitions SHALL be: FREEZE -> RUN when mem_busy=0.
REQ-017 Transitions SHALL be: RUN -> BUBBLE when load_use=1, mem_busy=0 and effective flush=0.
REQ-018 Transitions SHALL be: BUBBLE -> RUN when mem_busy=0, even if load_use is still 1, since the slot now holds a bubble.
REQ-019 In FREEZE, all three slots SHALL hold their values.
REQ-020 In FREEZE, freeze=1 and stall=1.
REQ-021 When not frozen, the slots SHALL advance on each edge: MEM/WB <= EX/MEM, then EX/MEM <= ID/EX.
REQ-022 When not frozen, ID/EX SHALL load a bubble if effective flush=1, if load_use=1, or if dec_valid=0; otherwise it loads {dec_rd, dec_regwrite, dec_memread}.
REQ-023 Effective flush SHALL be flush OR pending_flush.
REQ-024 Flush SHALL take priority over load_use: stall=0, a bubble is inserted and the next state is RUN.
REQ-025 A flush asserted while mem_busy=1 SHALL set pending_flush.
REQ-026 pending_flush SHALL apply on the first unfrozen edge and then clear.
REQ-027 stall SHALL be mem_busy OR (load_use AND NOT effective flush), combinational.
REQ-028 freeze SHALL equal mem_busy, combinational.
REQ-029 stall_cnt SHALL increment by 1 on every edge with stall=1.
REQ-030 stall_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-031 A decode write to x0 SHALL be stored as given; consumers ignore rd=0, and load_use already excludes idex_rd=0.

Reset
REQ-032 While rst=1, all slots SHALL be bubbles.
REQ-033 While rst=1, state=RUN, pending_flush=0 and stall_cnt=0, asynchronously and independent of clk.
REQ-034 Reset SHALL abort any BUBBLE or FREEZE immediately.
REQ-035 Reset SHALL discard any pending flush.
REQ-036 The first edge after rst deasserts SHALL behave as RUN.

Verification
REQ-037 Load-use: load x5 in ID/EX with id_rs1=5 and id_uses_rs1=1 -> stall=1 for exactly 1 cycle; ID/EX becomes a bubble; state RUN->BUBBLE->RUN; stall_cnt=1.
REQ-038 Forward feed: decode rd=7 with regwrite=1, no stalls -> RD_ex_mem=7 and EX_MEM_RegWrite=1 two edges later; RD_mem_wb=7 three edges later.
REQ-039 Flush vs load_use: flush=1 in the same cycle as load_use=1 -> stall=0, ID/EX is a bubble, state stays RUN.
REQ-040 Freeze with flush: mem_busy=1 for 3 cycles with a flush pulse in cycle 2 -> all slots unchanged, freeze=1; ID/EX is a bubble on the first free edge; stall_cnt +3.
REQ-041 Mid-operation reset: assert rst while in BUBBLE with pending_flush=1 -> all outputs 0 and state=RUN before the next clk edge.
REQ-042 Saturation: hold mem_busy=1 for 65540 cycles -> stall_cnt=16'hFFFF and stays there.
